// File: rtl/hdmi_video_timing.sv
// Raster timing generator with fixed-latency pixel fetch for the HDMI encoder stage.
// Latency: req_* one clock after the counters; active/h_sync/v_sync/rgb PIXEL_LATENCY clocks after req_*.
// Backpressure: none; the pixel source must return pix_data exactly PIXEL_LATENCY clocks after each request.
//
// Ports:
//   clk, reset_n         pixel clock, synchronous active-low reset
//   req_valid/req_x/req_y pixel request to the upstream source (coordinates hold while idle)
//   pix_data             {R,G,B} returned by the source
//   frame_start          one-clock pulse when the counters are at (0,0)
//   active/h_sync/v_sync/rgb  encoder-facing timing and pixel, mutually aligned
module hdmi_video_timing #(
   parameter int H_ACTIVE      = 640,
   parameter int H_FRONT       = 16,
   parameter int H_SYNC        = 96,
   parameter int H_BACK        = 48,
   parameter int V_ACTIVE      = 480,
   parameter int V_FRONT       = 10,
   parameter int V_SYNC        = 2,
   parameter int V_BACK        = 33,
   parameter int H_POLARITY    = 0,
   parameter int V_POLARITY    = 0,
   parameter int PIXEL_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        req_valid,
   output logic [11:0] req_x,
   output logic [10:0] req_y,
   input  logic [23:0] pix_data,
   output logic        frame_start,
   output logic        active,
   output logic        h_sync,
   output logic        v_sync,
   output logic [23:0] rgb
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

   // Sync region bounds, kept as int so a sync ending exactly at the
   // counter range limit cannot wrap to zero.
   localparam int HS_BEGIN = H_ACTIVE + H_FRONT;
   localparam int HS_END   = H_ACTIVE + H_FRONT + H_SYNC;
   localparam int VS_BEGIN = V_ACTIVE + V_FRONT;
   localparam int VS_END   = V_ACTIVE + V_FRONT + V_SYNC;

   localparam logic HS_ON = 1'(H_POLARITY);
   localparam logic VS_ON = 1'(V_POLARITY);

   if (H_TOTAL > 4096) begin : g_bad_h_total
      $error("hdmi_video_timing: H_TOTAL must not exceed 4096");
   end
   if (V_TOTAL > 2048) begin : g_bad_v_total
      $error("hdmi_video_timing: V_TOTAL must not exceed 2048");
   end
   if (PIXEL_LATENCY < 1 || PIXEL_LATENCY > 8) begin : g_bad_latency
      $error("hdmi_video_timing: PIXEL_LATENCY must be in 1..8");
   end

   logic [11:0] h;
   logic [10:0] v;

   logic visible;
   logic hs_cond;
   logic vs_cond;

   logic s0_hs;
   logic s0_vs;

   logic [PIXEL_LATENCY-1:0] act_d;
   logic [PIXEL_LATENCY-1:0] hs_d;
   logic [PIXEL_LATENCY-1:0] vs_d;

   // Raster counters: v advances only on the h wrap.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + 11'd1;
      end else begin
         h <= h + 12'd1;
      end
   end

   assign visible = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
   assign hs_cond = (int'(h) >= HS_BEGIN) && (int'(h) < HS_END);
   // Vertical sync looks at v alone, so it toggles on the clock h wraps.
   assign vs_cond = (int'(v) >= VS_BEGIN) && (int'(v) < VS_END);

   // Stage 0: request port plus the timing conditions that travel with it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         req_valid   <= 1'b0;
         req_x       <= '0;
         req_y       <= '0;
         frame_start <= 1'b0;
         s0_hs       <= ~HS_ON;
         s0_vs       <= ~VS_ON;
      end else begin
         req_valid   <= visible;
         if (visible) begin
            req_x <= h;
            req_y <= v;
         end
         frame_start <= (h == 12'd0) && (v == 11'd0);
         s0_hs       <= hs_cond ? HS_ON : ~HS_ON;
         s0_vs       <= vs_cond ? VS_ON : ~VS_ON;
      end
   end

   // Delay line matching the pixel source latency, so the encoder sees
   // timing and the returned pixel for the same raster position together.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         act_d <= '0;
         hs_d  <= {PIXEL_LATENCY{~HS_ON}};
         vs_d  <= {PIXEL_LATENCY{~VS_ON}};
      end else begin
         act_d[0] <= req_valid;
         hs_d[0]  <= s0_hs;
         vs_d[0]  <= s0_vs;
         for (int i = 1; i < PIXEL_LATENCY; i++) begin
            act_d[i] <= act_d[i-1];
            hs_d[i]  <= hs_d[i-1];
            vs_d[i]  <= vs_d[i-1];
         end
      end
   end

   assign active = act_d[PIXEL_LATENCY-1];
   assign h_sync = hs_d[PIXEL_LATENCY-1];
   assign v_sync = vs_d[PIXEL_LATENCY-1];

   // The source is only trusted on active pixels; blanking is forced black.
   assign rgb = active ? pix_data : 24'h0;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing: four instances (three latencies at 640x480,
// plus a tiny active-high-sync raster) against a position-based model.
module tb_hdmi_video_timing;

   localparam int NI   = 4;
   localparam int NCYC = 22000;

   localparam int P_HA [NI] = '{640, 640, 640, 8};
   localparam int P_HF [NI] = '{16, 16, 16, 2};
   localparam int P_HS [NI] = '{96, 96, 96, 3};
   localparam int P_HB [NI] = '{48, 48, 48, 2};
   localparam int P_VA [NI] = '{480, 480, 480, 4};
   localparam int P_VF [NI] = '{10, 10, 10, 1};
   localparam int P_VS [NI] = '{2, 2, 2, 2};
   localparam int P_VB [NI] = '{33, 33, 33, 1};
   localparam int P_HP [NI] = '{0, 0, 0, 1};
   localparam int P_VP [NI] = '{0, 0, 0, 1};
   localparam int P_LAT[NI] = '{2, 1, 5, 3};

   typedef struct {
      logic        rv;
      logic [11:0] rx;
      logic [10:0] ry;
      logic        fs;
      logic        act;
      logic        hs;
      logic        vs;
      logic [23:0] rgb;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n [NI];
   logic        rv    [NI];
   logic [11:0] rx    [NI];
   logic [10:0] ry    [NI];
   logic [23:0] pix   [NI];
   logic        fs    [NI];
   logic        act   [NI];
   logic        hs    [NI];
   logic        vs    [NI];
   logic [23:0] rgb   [NI];

   // Source model history: request seen at each cycle, indexed by cycle mod 16.
   logic [11:0] hist_x [NI][16];
   logic [10:0] hist_y [NI][16];
   logic        hist_v [NI][16];

   int k [NI];      // edges since reset_n was last sampled low (-1: never)
   int cyc;
   int n_checks = 0;
   int n_fail   = 0;
   bit mid_done = 1'b0;

   always #5 clk = ~clk;

   hdmi_video_timing u_dut0 (
      .clk(clk), .reset_n(rst_n[0]), .req_valid(rv[0]), .req_x(rx[0]), .req_y(ry[0]),
      .pix_data(pix[0]), .frame_start(fs[0]), .active(act[0]), .h_sync(hs[0]),
      .v_sync(vs[0]), .rgb(rgb[0]));

   hdmi_video_timing #(.PIXEL_LATENCY(1)) u_dut1 (
      .clk(clk), .reset_n(rst_n[1]), .req_valid(rv[1]), .req_x(rx[1]), .req_y(ry[1]),
      .pix_data(pix[1]), .frame_start(fs[1]), .active(act[1]), .h_sync(hs[1]),
      .v_sync(vs[1]), .rgb(rgb[1]));

   hdmi_video_timing #(.PIXEL_LATENCY(5)) u_dut2 (
      .clk(clk), .reset_n(rst_n[2]), .req_valid(rv[2]), .req_x(rx[2]), .req_y(ry[2]),
      .pix_data(pix[2]), .frame_start(fs[2]), .active(act[2]), .h_sync(hs[2]),
      .v_sync(vs[2]), .rgb(rgb[2]));

   hdmi_video_timing #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .H_POLARITY(1), .V_POLARITY(1), .PIXEL_LATENCY(3)
   ) u_dut3 (
      .clk(clk), .reset_n(rst_n[3]), .req_valid(rv[3]), .req_x(rx[3]), .req_y(ry[3]),
      .pix_data(pix[3]), .frame_start(fs[3]), .active(act[3]), .h_sync(hs[3]),
      .v_sync(vs[3]), .rgb(rgb[3]));

   function automatic int h_tot(int i);
      return P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
   endfunction

   function automatic int v_tot(int i);
      return P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
   endfunction

   // Expected outputs kk edges after reset release: stage-0 outputs describe
   // raster position kk-1, the aligned outputs describe position kk-1-latency.
   function automatic exp_t model(int i, int kk);
      exp_t e;
      int   q, h, v, ft;
      ft    = h_tot(i) * v_tot(i);
      e.rv  = 1'b0;
      e.rx  = '0;
      e.ry  = '0;
      e.fs  = 1'b0;
      e.act = 1'b0;
      e.hs  = (P_HP[i] == 0);
      e.vs  = (P_VP[i] == 0);
      e.rgb = '0;
      if (kk >= 1) begin
         q    = (kk - 1) % ft;
         h    = q % h_tot(i);
         v    = q / h_tot(i);
         e.fs = (q == 0);
         e.rv = (h < P_HA[i]) && (v < P_VA[i]);
         // Coordinates hold the last requested pixel while idle.
         if (e.rv) begin
            e.rx = 12'(h);
            e.ry = 11'(v);
         end else if (v < P_VA[i]) begin
            e.rx = 12'(P_HA[i] - 1);
            e.ry = 11'(v);
         end else begin
            e.rx = 12'(P_HA[i] - 1);
            e.ry = 11'(P_VA[i] - 1);
         end
      end
      if (kk - 1 - P_LAT[i] >= 0) begin
         q     = (kk - 1 - P_LAT[i]) % ft;
         h     = q % h_tot(i);
         v     = q / h_tot(i);
         e.act = (h < P_HA[i]) && (v < P_VA[i]);
         if (h >= P_HA[i] + P_HF[i] && h < P_HA[i] + P_HF[i] + P_HS[i])
            e.hs = (P_HP[i] != 0);
         if (v >= P_VA[i] + P_VF[i] && v < P_VA[i] + P_VF[i] + P_VS[i])
            e.vs = (P_VP[i] != 0);
         if (e.act)
            e.rgb = {8'(h), 8'(v), 8'hA5};
      end
      return e;
   endfunction

   task automatic check(input string nm, input int i, input logic [23:0] got,
                        input logic [23:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", nm, i, cyc, got, want);
      end
   endtask

   // Stimulus: resets, source model returning {x,y,A5} after the latency,
   // random garbage on pix_data whenever no request is outstanding.
   initial begin
      int rs_cnt;
      int slot;
      int rd;
      rs_cnt = 0;
      cyc    = 0;
      for (int i = 0; i < NI; i++) begin
         rst_n[i] = 1'b0;
         pix[i]   = '0;
         k[i]     = -1;
         for (int s = 0; s < 16; s++) begin
            hist_x[i][s] = '0;
            hist_y[i][s] = '0;
            hist_v[i][s] = 1'b0;
         end
      end
      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         for (int i = 0; i < NI; i++) begin
            if (!rst_n[i])
               k[i] = 0;
            else if (k[i] >= 0)
               k[i]++;
         end
         cyc++;
         #1;
         slot = cyc % 16;
         for (int i = 0; i < NI; i++) begin
            hist_x[i][slot] = rx[i];
            hist_y[i][slot] = ry[i];
            hist_v[i][slot] = rv[i];
            rd = (cyc + 16 - P_LAT[i]) % 16;
            if (hist_v[i][rd])
               pix[i] = {hist_x[i][rd][7:0], hist_y[i][rd][7:0], 8'hA5};
            else
               pix[i] = 24'($urandom());
         end
         if (c == 4) begin
            for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
         end else if (c > 4) begin
            // One-clock reset while h_sync is low at raster (700,20).
            if (!rst_n[0])
               rst_n[0] = 1'b1;
            else if (!mid_done && (k[0] - 1 - P_LAT[0] == 20 * 800 + 700)) begin
               rst_n[0] = 1'b0;
               mid_done = 1'b1;
            end
            // Random short resets on the small raster.
            if (rs_cnt > 0) begin
               rs_cnt--;
               if (rs_cnt == 0) rst_n[3] = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
               rst_n[3] = 1'b0;
               rs_cnt   = int'($urandom_range(1, 3));
            end
         end
      end
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Measurement state for the default raster (inst 0) and small raster (inst 3).
   int  t_arise0 = -1, t_hfall0 = -1;
   logic p_act0 = 1'b0, p_hs0 = 1'b1;
   int  t_fs3 = -1, rises3 = 0, t_vrise3 = -1, t_hrise3 = -1;
   logic p_act3 = 1'b0, p_hs3 = 1'b0, p_vs3 = 1'b0;

   always @(negedge clk) begin : cmp
      exp_t e;
      int   p;
      for (int i = 0; i < NI; i++) begin
         if (k[i] >= 0) begin
            e = model(i, k[i]);
            check("req_valid",   i, 24'(rv[i]),  24'(e.rv));
            check("req_x",       i, 24'(rx[i]),  24'(e.rx));
            check("req_y",       i, 24'(ry[i]),  24'(e.ry));
            check("frame_start", i, 24'(fs[i]),  24'(e.fs));
            check("active",      i, 24'(act[i]), 24'(e.act));
            check("h_sync",      i, 24'(hs[i]),  24'(e.hs));
            check("v_sync",      i, 24'(vs[i]),  24'(e.vs));
            check("rgb",         i, rgb[i],      e.rgb);
         end
         // Hand-computed pixels of row 3 at each latency.
         if (i < 3 && k[i] >= 1) begin
            p = k[i] - 1 - P_LAT[i];
            if (p == 3 * 800)       check("row3_first_rgb", i, rgb[i], 24'h0003A5);
            if (p == 3 * 800 + 639) check("row3_last_rgb",  i, rgb[i], 24'h7F03A5);
         end
      end

      // Literal reset / startup expectations, default raster.
      if (k[0] == 0) begin
         check("rst_active", 0, 24'(act[0]), 24'h0);
         check("rst_hsync",  0, 24'(hs[0]),  24'h1);
         check("rst_vsync",  0, 24'(vs[0]),  24'h1);
         check("rst_rgb",    0, rgb[0],      24'h0);
         check("rst_req",    0, 24'(rv[0]),  24'h0);
      end
      if (k[0] == 1) check("first_frame_start", 0, 24'(fs[0]), 24'h1);
      if (k[0] == 2) check("active_not_early",  0, 24'(act[0]), 24'h0);
      if (k[0] == 3) check("active_rise_lat2",  0, 24'(act[0]), 24'h1);
      if (k[3] == 0) begin
         check("pol_rst_hsync", 3, 24'(hs[3]), 24'h0);
         check("pol_rst_vsync", 3, 24'(vs[3]), 24'h0);
      end

      // Line timing on the default raster.
      if (k[0] <= 0) begin
         t_arise0 = -1;
         t_hfall0 = -1;
      end else begin
         if (act[0] && !p_act0) t_arise0 = cyc;
         if (!act[0] && p_act0 && t_arise0 >= 0)
            check("active_width", 0, 24'(cyc - t_arise0), 24'd640);
         if (!hs[0] && p_hs0) begin
            if (t_arise0 >= 0 && cyc - t_arise0 <= 800)
               check("hsync_offset", 0, 24'(cyc - t_arise0), 24'd656);
            if (t_hfall0 >= 0)
               check("line_period", 0, 24'(cyc - t_hfall0), 24'd800);
            t_hfall0 = cyc;
         end
         if (hs[0] && !p_hs0 && t_hfall0 >= 0)
            check("hsync_width", 0, 24'(cyc - t_hfall0), 24'd96);
      end
      p_act0 = act[0];
      p_hs0  = hs[0];

      // Frame timing on the small active-high raster (15 x 8 = 120 clocks).
      if (k[3] <= 0) begin
         t_fs3    = -1;
         rises3   = 0;
         t_vrise3 = -1;
         t_hrise3 = -1;
      end else begin
         if (act[3] && !p_act3) rises3++;
         if (fs[3]) begin
            if (t_fs3 >= 0) begin
               check("frame_period",   3, 24'(cyc - t_fs3), 24'd120);
               check("rows_per_frame", 3, 24'(rises3), 24'd4);
            end
            t_fs3  = cyc;
            rises3 = 0;
         end
         if (vs[3] && !p_vs3) t_vrise3 = cyc;
         if (!vs[3] && p_vs3 && t_vrise3 >= 0)
            check("vsync_width", 3, 24'(cyc - t_vrise3), 24'd30);
         if (hs[3] && !p_hs3) t_hrise3 = cyc;
         if (!hs[3] && p_hs3 && t_hrise3 >= 0)
            check("hsync_width_pol", 3, 24'(cyc - t_hrise3), 24'd3);
      end
      p_act3 = act[3];
      p_hs3  = hs[3];
      p_vs3  = vs[3];
   end

endmodule

// File: doc/hdmi_video_timing.md
Name: hdmi_video_timing

Overview:
Generates raster timing for the HDMI output path and fetches pixels from an upstream pixel source, such as a framebuffer or pattern generator, through a fixed-latency request port. It drives the active, h_sync, v_sync and rgb inputs of the HDMI encoder stage directly. Those outputs are aligned so that rgb belongs to the same pixel as active.
Defaults are 640x480@60 with a 25.175 MHz pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
H_POLARITY, 0, asserted level of h_sync (0 = active-low)
V_POLARITY, 0, asserted level of v_sync
PIXEL_LATENCY, 2, clocks from request to pixel data valid; legal range 1..8

Ports:
clk  input  1  pixel clock
reset_n  input  1  synchronous active-low reset
req_valid  output  1  pixel request for (req_x, req_y)
req_x  output  12  requested column
req_y  output  11  requested row
pix_data  input  24  pixel {R,G,B}; valid exactly PIXEL_LATENCY clocks after the matching request
frame_start  output  1  one-clock pulse when the counters are at (0,0)
active  output  1  visible pixel, to the encoder
h_sync  output  1  horizontal sync, to the encoder
v_sync  output  1  vertical sync, to the encoder
rgb  output  24  pixel, to the encoder; zero outside active

Behaviour:
- The block uses one clock. Reset is synchronous and active-low: reset_n is sampled on the rising edge of clk.
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK.
  - V_TOTAL likewise from the V_ parameters.
- Counters:
  - h is a register from 0 to H_TOTAL-1. It wraps to 0 after H_TOTAL-1.
  - v increments only when h wraps. It wraps to 0 after V_TOTAL-1; when h=H_TOTAL-1 and v=V_TOTAL-1, the next state is (0,0).
- Region order within a line: active [0, H_ACTIVE), then front porch, then sync [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC), then back porch. Vertical regions follow the same order.
- v_sync is evaluated on v only. It changes on the same clock as h wraps to 0.
- Stage-0 signals are registered outputs derived directly from the counter registers:
  - req_valid = (h < H_ACTIVE) && (v < V_ACTIVE).
  - req_x = h and req_y = v; these hold their values when req_valid is 0.
  - frame_start = (h == 0) && (v == 0).
- Alignment:
  - active, h_sync and v_sync are the stage-0 active, h-sync and v-sync conditions delayed through a PIXEL_LATENCY-deep shift register.
  - rgb = active ? pix_data : 24'h0. So rgb at cycle t is the pixel requested at cycle t - PIXEL_LATENCY.
- Sync levels: each sync output equals its POLARITY value when asserted and the inverse otherwise.
- Reset values while reset_n = 0:
  - h = 0, v = 0.
  - req_valid = 0, req_x = 0, req_y = 0, frame_start = 0.
  - All delay stages are cleared to inactive with syncs deasserted: active = 0, h_sync = !H_POLARITY, v_sync = !V_POLARITY, rgb = 0.
- First clock after reset_n rises: counters are at (0,0), so frame_start = 1 and req_valid = 1. active first rises PIXEL_LATENCY clocks later.
- Reset mid-frame: on the next edge, every output takes its reset value regardless of the current region. No partial sync pulse persists past the reset edge.
- pix_data is ignored whenever the delayed active is 0.
- No backpressure: the pixel source must meet the fixed latency.
- Widths: sums are computed in 12 bits (H) and 11 bits (V). Parameters must satisfy H_TOTAL ≤ 4096 and V_TOTAL ≤ 2048; an elaboration check flags violations.

Test Plan:
1. Reset check: hold reset_n = 0 for 5 clocks, then release. Required response:
   - During reset: active = 0, h_sync = 1, v_sync = 1, rgb = 0, req_valid = 0.
   - First released clock: frame_start = 1.
   - active = 1 exactly 2 clocks after that clock, with default parameters.
2. Line timing, defaults: per line, active is high for 640 clocks. h_sync is low for exactly 96 clocks, starting 656 clocks after active rises. Line period is 800 clocks.
3. Frame timing: per frame there are 480 lines containing active, and v_sync is low for 2 × 800 clocks. frame_start pulses every 420000 clocks; v wraps 524 → 0 together with h wrapping 799 → 0.
4. Alignment: a source model returns {x[7:0], y[7:0], 8'hA5} PIXEL_LATENCY clocks after each request. Required rgb:
   - At the first active clock of row 3: 24'h0003A5.
   - At the last active clock of that row: 24'h7F03A5.
   - Repeat with PIXEL_LATENCY = 1 and 5.
5. Reset mid-operation: assert reset_n = 0 while h_sync is low at (h=700, v=100) for 1 clock. Next edge: h_sync = 1 and active = 0. Timing then restarts from (0,0) with frame_start = 1.
6. Polarity: set H_POLARITY = 1, V_POLARITY = 1. Syncs idle at 0 and pulse high with the widths from scenarios 2–3. Reset drives both to 0.
